// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage register pipeline of WIDTH-bit words with
// valid/ready flow control, bubble collapsing, synchronous flush and a
// registered occupancy count.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over flush)
//   flush      synchronous clear of every stage
//   in_valid   producer offers in_data
//   in_ready   pipeline accepts in_data this cycle
//   in_data    input word
//   out_valid  last stage holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_data   word held in the last stage
//   count      number of valid stages, 0..DEPTH
module reg_pipeline #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Stage state: index 0 is the input side, DEPTH-1 the output side.
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic [DEPTH-1:0] r_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  // Per-stage ready chain. r[i] = ~v[i] | r[i+1] is unrolled into a running
  // OR from the output side so an empty stage anywhere downstream lets the
  // stages above it advance (bubble collapsing) without a combinational
  // self-reference on the r_s vector.
  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    r_s   = {DEPTH{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = chain | ~v_q[i];
      r_s[i] = chain;
    end
  end

  assign in_ready_s = r_s[0] & ~flush & ~rst;
  assign in_xfer_s  = in_valid & in_ready_s;
  assign out_xfer_s = v_q[DEPTH-1] & out_ready;

  // Next-state for valid bits, stage data and occupancy count.
  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (rst || flush) begin
      // Flush behaves like reset; a consumer handshake in this cycle is
      // still taken by the consumer, the count is simply forced to zero.
      v_d     = {DEPTH{1'b0}};
      count_d = {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        d_d[i] = RESET_VAL;
      end
    end else begin
      if (r_s[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          d_d[0] = in_data;
        end else begin
          d_d[0] = d_q[0];
        end
      end else begin
        v_d[0] = v_q[0];
      end
      // Data only moves with a valid word, so the last stage keeps its
      // previous word on out_data while out_valid is low.
      for (int i = 1; i < DEPTH; i++) begin
        if (r_s[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end else begin
            d_d[i] = d_q[i];
          end
        end else begin
          v_d[i] = v_q[i];
        end
      end
      count_d = count_q + CW'(in_xfer_s) - CW'(out_xfer_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= {DEPTH{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: instance A (DEPTH=2, RESET_VAL=FF) and instance B
// (DEPTH=3, RESET_VAL=00). A negedge scoreboard pushes every accepted word
// and pops/compares on every consumed word; directed steps check the
// timing-specific values.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [7:0] qa [$];
  logic [7:0] qb [$];

  always #5 clk = ~clk;

  reg_pipeline #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hFF)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: count must equal words in flight; consumed words come out in order.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_count_sb", 32'(a_count), 32'(qa.size()));
      chk("b_count_sb", 32'(b_count), 32'(qb.size()));
      if (a_out_valid && a_out_ready) begin
        chk("a_out_has_word", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) chk("a_out_data_sb", 32'(a_out_data), 32'(qa.pop_front()));
      end
      if (b_out_valid && b_out_ready) begin
        chk("b_out_has_word", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_out_data_sb", 32'(b_out_data), 32'(qb.pop_front()));
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      if (rst || a_flush) qa.delete();
      if (rst || b_flush) qb.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h11; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h11; b_out_ready = 1'b0;

    // 1. Reset held with a word offered: nothing captured, outputs at RESET_VAL.
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data", 32'(a_out_data), 32'hFF);
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_b_out_data", 32'(b_out_data), 32'h00);
      tick();
    end
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("rel_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rel_b_in_ready", 32'(b_in_ready), 32'd1);
    tick();

    // 2. Streaming on A with out_ready high.
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'h05;
    tick();
    chk("str_ov0", 32'(a_out_valid), 32'd0);
    chk("str_cnt1", 32'(a_count), 32'd1);
    a_in_data = 8'h0A;
    tick();
    chk("str_ov1", 32'(a_out_valid), 32'd1);
    chk("str_od05", 32'(a_out_data), 32'h05);
    chk("str_cnt_peak", 32'(a_count), 32'd2);
    a_in_data = 8'h03;
    tick();
    chk("str_od0A", 32'(a_out_data), 32'h0A);
    chk("str_cnt2", 32'(a_count), 32'd2);
    a_in_valid = 1'b0;
    tick();
    chk("str_od03", 32'(a_out_data), 32'h03);
    chk("str_cnt_1b", 32'(a_count), 32'd1);
    tick();
    chk("str_empty_ov", 32'(a_out_valid), 32'd0);
    chk("str_hold_od", 32'(a_out_data), 32'h03);
    chk("str_empty_cnt", 32'(a_count), 32'd0);

    // 3. Backpressure: fill with 01, 02, then 03 must wait.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_data = 8'h02;
    #1;
    chk("bp_ready_2nd", 32'(a_in_ready), 32'd1);
    tick();
    a_in_data = 8'h03;
    #1;
    chk("bp_in_ready0", 32'(a_in_ready), 32'd0);
    chk("bp_cnt2", 32'(a_count), 32'd2);
    tick();
    chk("bp_stall_cnt", 32'(a_count), 32'd2);
    chk("bp_stall_od", 32'(a_out_data), 32'h01);
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("bp_od02", 32'(a_out_data), 32'h02);
    a_in_data = 8'h04;
    tick();
    chk("bp_od03", 32'(a_out_data), 32'h03);
    a_in_valid = 1'b0;
    tick();
    chk("bp_od04", 32'(a_out_data), 32'h04);
    chk("bp_cnt1", 32'(a_count), 32'd1);
    tick();
    chk("bp_drained", 32'(a_out_valid), 32'd0);

    // 4. Bubble collapse on B (DEPTH=3), consumer stalled.
    b_in_valid = 1'b1; b_in_data = 8'hA1;
    tick();
    b_in_valid = 1'b0;
    tick();
    b_in_valid = 1'b1; b_in_data = 8'hA2;
    #1;
    chk("bub_ready_a2", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    #1;
    chk("bub_cnt2", 32'(b_count), 32'd2);
    chk("bub_ready", 32'(b_in_ready), 32'd1);
    tick();
    chk("bub_adj_cnt", 32'(b_count), 32'd2);
    chk("bub_adj_ready", 32'(b_in_ready), 32'd1);
    chk("bub_od_a1", 32'(b_out_data), 32'hA1);
    b_out_ready = 1'b1;
    tick();
    chk("bub_od_a2", 32'(b_out_data), 32'hA2);
    chk("bub_ov_a2", 32'(b_out_valid), 32'd1);
    tick();
    chk("bub_done", 32'(b_out_valid), 32'd0);

    // 5. Flush with 05 and 0A held while 03 is offered.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h05;
    tick();
    a_in_data = 8'h0A;
    tick();
    chk("fl_pre_cnt", 32'(a_count), 32'd2);
    a_flush = 1'b1; a_in_data = 8'h03;
    #1;
    chk("fl_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_cnt", 32'(a_count), 32'd0);
    chk("fl_ov", 32'(a_out_valid), 32'd0);
    chk("fl_od", 32'(a_out_data), 32'hFF);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_03", 32'(a_out_valid), 32'd0);
    end

    // 6. Full pipeline: one in, one out per cycle for 10 cycles.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h20;
    tick();
    a_in_data = 8'h21;
    tick();
    chk("full_cnt", 32'(a_count), 32'd2);
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = 8'h22 + 8'(i);
      #1;
      chk("full_in_ready", 32'(a_in_ready), 32'd1);
      tick();
      chk("full_cnt_hold", 32'(a_count), 32'd2);
      chk("full_od", 32'(a_out_data), 32'(8'h21 + 8'(i)));
    end
    a_in_valid = 1'b0;
    tick();
    tick();
    chk("full_drain_cnt", 32'(a_count), 32'd0);
    tick();
    chk("sb_a_empty", 32'(qa.size()), 32'd0);
    chk("sb_b_empty", 32'(qb.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
